// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined WIDTH-bit adder/subtractor. The operand is cut into SEGS equal
//   segments. Each segment is resolved by a GROUP-bit lookahead tree in its
//   own pipeline stage, and the carry is handed to the next stage through a
//   register. Operands above the current segment travel forward (skew), and
//   finished low sum slices travel forward (deskew), so a beat's slices all
//   exit together after SEGS cycles.
// Ports
//   i_clk, i_rst_n      : clock (rising edge), async active-low reset
//   i_valid / o_ready   : operand handshake
//   i_add1, i_add2      : operands A, B
//   i_cin               : carry-in (add mode only)
//   i_sub               : 1 = A - B (B inverted, carry-in forced to 1)
//   o_valid / i_ready   : result handshake
//   o_result            : {carry_out, sum}
//   o_ovf               : signed overflow (carry into MSB ^ carry out)
module cla_pipe_adder #(
  parameter int WIDTH = 52,
  parameter int SEGS  = 4,
  parameter int GROUP = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_ovf
);

  localparam int unsigned SEG_W = WIDTH / SEGS;
  localparam int unsigned NGRP  = (SEG_W + GROUP - 1) / GROUP;
  localparam int unsigned LAST  = SEGS - 1;

  if (WIDTH % SEGS != 0) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be divisible by SEGS");
  end
  if (SEGS < 1 || SEGS > 8) begin : g_bad_segs
    $error("cla_pipe_adder: SEGS must be in 1..8");
  end
  if (GROUP < 1) begin : g_bad_group
    $error("cla_pipe_adder: GROUP must be at least 1");
  end

  typedef struct packed {
    logic [SEG_W-1:0] sum;
    logic             cout;
    logic             cmsb;   // carry into the segment's top bit
  } seg_res_t;

  // Lookahead over one segment. Group generate/propagate produce each
  // group's carry-out; the last group may be narrower than GROUP.
  function automatic seg_res_t cla_seg(input logic [SEG_W-1:0] a,
                                       input logic [SEG_W-1:0] b,
                                       input logic             cin);
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c;
    logic             gg;
    logic             gp;
    logic             gc;
    int unsigned      idx;
    seg_res_t         r;
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gc = cin;
    for (int unsigned grp = 0; grp < NGRP; grp++) begin
      gg = 1'b0;
      gp = 1'b1;
      c[grp*GROUP] = gc;
      for (int unsigned j = 0; j < GROUP; j++) begin
        idx = grp * GROUP + j;
        if (idx < SEG_W) begin
          c[idx+1] = g[idx] | (p[idx] & c[idx]);
          gg       = g[idx] | (p[idx] & gg);
          gp       = gp & p[idx];
        end
      end
      gc = gg | (gp & gc);
    end
    c[SEG_W] = gc;
    r.sum    = p ^ c[SEG_W-1:0];
    r.cout   = c[SEG_W];
    r.cmsb   = c[SEG_W-1];
    return r;
  endfunction

  // Stage registers
  logic             v_q   [SEGS];
  logic             v_d   [SEGS];
  logic [WIDTH-1:0] a_q   [SEGS];
  logic [WIDTH-1:0] a_d   [SEGS];
  logic [WIDTH-1:0] b_q   [SEGS];
  logic [WIDTH-1:0] b_d   [SEGS];
  logic [WIDTH-1:0] sum_q [SEGS];
  logic [WIDTH-1:0] sum_d [SEGS];
  logic             c_q   [SEGS];
  logic             c_d   [SEGS];
  logic             ovf_q;
  logic             ovf_d;

  // Stage inputs: stage 0 sees the ports, stage k sees stage k-1 registers
  logic             in_v [SEGS];
  logic [WIDTH-1:0] in_a [SEGS];
  logic [WIDTH-1:0] in_b [SEGS];
  logic [WIDTH-1:0] in_s [SEGS];
  logic             in_c [SEGS];

  logic adv;

  assign o_valid  = v_q[LAST];
  assign o_ready  = !v_q[LAST] || i_ready;
  assign adv      = o_ready;
  assign o_result = {c_q[LAST], sum_q[LAST]};
  assign o_ovf    = ovf_q;

  always_comb begin
    in_v[0] = i_valid;
    in_a[0] = i_add1;
    in_b[0] = i_sub ? ~i_add2 : i_add2;
    in_s[0] = '0;
    in_c[0] = i_sub | i_cin;
    for (int unsigned k = 1; k < SEGS; k++) begin
      in_v[k] = v_q[k-1];
      in_a[k] = a_q[k-1];
      in_b[k] = b_q[k-1];
      in_s[k] = sum_q[k-1];
      in_c[k] = c_q[k-1];
    end
  end

  // Data registers load only when a valid beat moves in, so the output
  // holds the last result across bubbles instead of clearing.
  always_comb begin
    seg_res_t seg;
    ovf_d = ovf_q;
    for (int unsigned k = 0; k < SEGS; k++) begin
      seg      = cla_seg(in_a[k][k*SEG_W +: SEG_W], in_b[k][k*SEG_W +: SEG_W], in_c[k]);
      v_d[k]   = adv ? in_v[k] : v_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
      c_d[k]   = c_q[k];
      if (adv && in_v[k]) begin
        a_d[k]                      = in_a[k];
        b_d[k]                      = in_b[k];
        sum_d[k]                    = in_s[k];
        sum_d[k][k*SEG_W +: SEG_W]  = seg.sum;
        c_d[k]                      = seg.cout;
        if (k == LAST) begin
          ovf_d = seg.cmsb ^ seg.cout;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < SEGS; k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < SEGS; k++) begin
        v_q[k]   <= v_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
        c_q[k]   <= c_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined successor to the single-cycle 52-bit carry-lookahead adder. It splits a WIDTH-bit add/subtract into SEGS equal segments. Each segment uses a 4-bit-group carry-lookahead tree, one segment per pipeline stage, and the carry ripples between stages through registers. It sits on datapath paths too wide for single-cycle CLA timing, with valid/ready flow control on both sides.

Parameters:
WIDTH, 52, operand width in bits; must be divisible by SEGS (elaboration error otherwise)
SEGS, 4, pipeline segments/stages; 1..8; SEG_W = WIDTH/SEGS
GROUP, 4, lookahead group size inside a segment; SEG_W need not be a multiple (last group narrower)

Ports:
i_clk  input  1  clock, rising-edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  operand beat valid
o_ready  output  1  block can accept a beat this cycle
i_add1  input  WIDTH  operand A
i_add2  input  WIDTH  operand B
i_cin  input  1  carry-in, add mode only
i_sub  input  1  1 = A - B (B inverted, carry-in forced 1, i_cin ignored)
o_valid  output  1  result beat valid
i_ready  input  1  downstream accepts result
o_result  output  WIDTH+1  {carry_out, sum}
o_ovf  output  1  signed overflow (carry into MSB XOR carry out)

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid bits 0, o_valid 0, o_result 0, o_ovf 0, internal carry/operand registers 0. Reset mid-operation discards all in-flight beats; nothing emerges after reset.
- Accept: a beat transfers when i_valid && o_ready. Produce: a beat completes when o_valid && i_ready.
- o_ready = !o_valid || i_ready (combinational). The whole pipeline advances as one unit on this enable; no bubbles are collapsed.
- Stage k (0..SEGS-1) computes sum bits [k*SEG_W +: SEG_W] from the registered operand slice and the carry registered by stage k-1. Stage 0 uses i_sub ? 1 : i_cin.
- Higher operand slices are carried forward in skew registers. Finished lower sum slices are carried forward in deskew registers. All slices of one beat exit together.
- Latency: SEGS cycles from accept to o_valid with no backpressure. Throughput: 1 beat/cycle.
- Back-to-back beats with different i_sub/i_cin never interfere. The mode is captured per beat and travels with it.
- Stall: while o_valid && !i_ready, all registers hold. o_result and o_ovf stay stable and o_valid stays high until taken.
- Simultaneous accept and produce in the same cycle is legal and the pipeline stays full.
- Subtract: o_result[WIDTH] = raw carry out of A + ~B + 1 (1 = no borrow). Sum wraps modulo 2^WIDTH.
- o_ovf is computed in the final stage from the carry into bit WIDTH-1 and carry_out. It is valid in both modes.
- SEGS=1 degenerates to a one-register-stage CLA with latency 1.
- o_result and o_ovf are don't-care when o_valid=0. They hold the last value and do not reset between beats.

Test Plan:
- Default params, add 0xF_FFFF_FFFF_FFFF + 0x0_0000_0000_0001, cin=0 -> after 4 cycles o_result = 0x1_0_0000_0000_0000 (carry out 1, sum 0); carry ripples through all 4 stages; o_ovf=0.
- Subtract 5 - 7 (WIDTH=52) -> sum 0xF_FFFF_FFFF_FFFE, carry_out 0, o_ovf 0. Then 0x8_0000_0000_0000 - 1 -> sum 0x7_FFFF_FFFF_FFFF, o_ovf 1.
- Stream 8 random beats with alternating i_sub and i_cin, i_ready=1 -> 8 consecutive o_valid cycles starting at cycle 4, each matching the reference model in order.
- Hold i_ready=0 for 6 cycles with the pipe full -> o_ready=0, o_result frozen, no beat lost or duplicated. On release, beats drain in order at 1/cycle.
- Assert i_rst_n=0 for 1 cycle with 3 beats in flight -> o_valid=0 immediately (asynchronous), o_result=0, and no stale beat appears after release.
- Re-run the directed and random tests with SEGS=1 (latency 1) and with WIDTH=64, SEGS=8, GROUP=3 -> results match the model, including the narrow last lookahead group.
